// File: rtl/ps2_defs.sv
// ps2_defs: shared state encodings, error codes and command constants
// for the PS/2 host transmitter and the keyboard receiver.
package ps2_defs;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_SEND,
      ST_ACK,
      ST_RELEASE,
      ST_ERR
   } tx_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_NACK    = 2'b10;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RESP_ACK     = 8'hFA;

   // Falling-edge count at which the stop bit goes out / the ACK arrives.
   localparam logic [3:0] FE_STOP = 4'd10;
   localparam logic [3:0] FE_ACK  = 4'd11;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Shift-out frame, LSB first: data, odd parity, stop.
   function automatic logic [9:0] make_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronises the raw PS/2 clock/data lines and flags
// clock falling edges. PS2_TX_GLITCH_FILTER_EN adds a 4-sample clock filter.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2clk_in,
   input  logic ps2data_in,
   output logic clk_s,
   output logic data_s,
   output logic fe
);

   logic [1:0] csync;
   logic [1:0] dsync;
   logic       lvl;
   logic       lvl_q;

   // Two-flop synchronisers; lines idle high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csync <= 2'b11;
         dsync <= 2'b11;
      end else begin
         csync <= {csync[0], ps2clk_in};
         dsync <= {dsync[0], ps2data_in};
      end
   end

`ifdef PS2_TX_GLITCH_FILTER_EN
   logic [1:0] run;
   logic       filt;

   // Level follows the line only after 4 consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt <= 1'b1;
         run  <= 2'd0;
      end else if (csync[1] == filt) begin
         run  <= 2'd0;
      end else if (run == 2'd3) begin
         filt <= csync[1];
         run  <= 2'd0;
      end else begin
         run  <= run + 2'd1;
      end
   end

   assign lvl = filt;
`else
   assign lvl = csync[1];
`endif

   // Previous clock level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lvl_q <= 1'b1;
      else     lvl_q <= lvl;
   end

   assign clk_s  = lvl;
   assign data_s = dsync[1];
   assign fe     = lvl_q & ~lvl;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ACK/NACK and
// timeout reporting. Optional clock glitch filter: PS2_TX_GLITCH_FILTER_EN.
module ps2_host_tx
   import ps2_defs::*;
#(
   parameter int INHIBIT_CYCLES    = 720,
   parameter int FIRST_EDGE_CYCLES = 90000,
   parameter int BIT_CYCLES        = 12000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2clk_in,
   input  logic       ps2data_in,
   output logic       ps2clk_oe,
   output logic       ps2data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   output logic [1:0] tx_err_code
);

   localparam int TMAX =
      max3(INHIBIT_CYCLES, FIRST_EDGE_CYCLES, BIT_CYCLES);
   localparam int TW = $clog2(TMAX + 1);

   tx_state_t      state, state_n;
   logic [TW-1:0]  timer, timer_n;
   logic [9:0]     shreg, shreg_n;
   logic [3:0]     bitcnt, bitcnt_n;
   logic           dlow, dlow_n;
   logic [1:0]     code, code_n;
   logic           clk_s, data_s, fe;
   logic           tmo;
   logic [3:0]     cnt_inc;

   ps2_line_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .ps2clk_in  (ps2clk_in),
      .ps2data_in (ps2data_in),
      .clk_s      (clk_s),
      .data_s     (data_s),
      .fe         (fe)
   );

   assign tmo         = (timer == '0);
   assign cnt_inc     = (bitcnt == FE_ACK) ? bitcnt : bitcnt + 4'd1;
   assign tx_err_code = code;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Frame shifter, bit counter, timer, data drive and error code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer  <= '0;
         shreg  <= '0;
         bitcnt <= '0;
         dlow   <= 1'b0;
         code   <= ERR_NONE;
      end else begin
         timer  <= timer_n;
         shreg  <= shreg_n;
         bitcnt <= bitcnt_n;
         dlow   <= dlow_n;
         code   <= code_n;
      end
   end

   // Next state, datapath updates and line/handshake outputs.
   always_comb begin
      state_n    = state;
      timer_n    = timer;
      shreg_n    = shreg;
      bitcnt_n   = bitcnt;
      dlow_n     = dlow;
      code_n     = code;
      ps2clk_oe  = 1'b0;
      ps2data_oe = 1'b0;
      tx_ready   = 1'b0;
      tx_busy    = 1'b1;
      tx_done    = 1'b0;
      tx_err     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            tx_ready = 1'b1;
            tx_busy  = 1'b0;
            if (tx_valid) begin
               state_n  = ST_INHIBIT;
               shreg_n  = make_frame(tx_data);
               timer_n  = TW'(INHIBIT_CYCLES - 1);
               bitcnt_n = '0;
               dlow_n   = 1'b0;
               code_n   = ERR_NONE;
            end
         end
         ST_INHIBIT: begin
            ps2clk_oe = 1'b1;
            if (tmo) state_n = ST_START;
            else     timer_n = timer - TW'(1);
         end
         ST_START: begin
            ps2clk_oe  = 1'b1;
            ps2data_oe = 1'b1;
            state_n    = ST_SEND;
            timer_n    = TW'(FIRST_EDGE_CYCLES);
            dlow_n     = 1'b1;
         end
         ST_SEND: begin
            ps2data_oe = dlow;
            if (fe) begin
               bitcnt_n = cnt_inc;
               timer_n  = TW'(BIT_CYCLES);
               dlow_n   = ~shreg[0];
               shreg_n  = {1'b0, shreg[9:1]};
               if (cnt_inc == FE_STOP) state_n = ST_ACK;
            end else if (tmo) begin
               state_n = ST_ERR;
               code_n  = ERR_TIMEOUT;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         ST_ACK: begin
            if (fe) begin
               bitcnt_n = cnt_inc;
               if (!data_s) begin
                  state_n = ST_RELEASE;
                  timer_n = TW'(BIT_CYCLES);
               end else begin
                  state_n = ST_ERR;
                  code_n  = ERR_NACK;
               end
            end else if (tmo) begin
               state_n = ST_ERR;
               code_n  = ERR_TIMEOUT;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         ST_RELEASE: begin
            if (clk_s && data_s) begin
               tx_done = 1'b1;
               state_n = ST_IDLE;
            end else if (tmo) begin
               state_n = ST_ERR;
               code_n  = ERR_TIMEOUT;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         ST_ERR: begin
            tx_err  = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench with a PS/2 device model, frame
// decoding and a cycle-level handshake/error-code model.
module tb_ps2_host_tx;
   import ps2_defs::*;

   localparam int INH  = 20;
   localparam int FEC  = 300;
   localparam int BITC = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2clk_in, ps2data_in;
   logic       ps2clk_oe, ps2data_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_busy, tx_done, tx_err;
   logic [1:0] tx_err_code;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int n_done = 0, n_err = 0;
   int last_pulse_cyc = 0, busy_rise_cyc = 0, last_fall_cyc = 0;
   logic [1:0] m_code = 2'b00;
   logic [1:0] m_exp = 2'b00;
   bit m_busy = 0, acc_prev = 0, pulse_prev = 0, busy_prev = 0;

   assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low);
   assign ps2data_in = ~(ps2data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES    (INH),
      .FIRST_EDGE_CYCLES (FEC),
      .BIT_CYCLES        (BITC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2clk_in   (ps2clk_in),
      .ps2data_in  (ps2data_in),
      .ps2clk_oe   (ps2clk_oe),
      .ps2data_oe  (ps2data_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .tx_err_code (tx_err_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bounded wait expired without the event", name);
   endtask

   // Per-cycle model: busy spans accept+1 .. pulse, code cleared on accept.
   always @(negedge clk) begin
      if (rst) begin
         m_busy = 0;
         m_code = ERR_NONE;
      end else begin
         if (pulse_prev) m_busy = 0;
         if (acc_prev) begin
            m_busy = 1;
            m_code = ERR_NONE;
         end
         if (tx_err) m_code = m_exp;
      end
      chk("busy", tx_busy, m_busy);
      chk("ready", tx_ready, !m_busy);
      chk("err_code", tx_err_code, m_code);
      chk("pulse_excl", tx_done & tx_err, 0);
      if (!m_busy)
         chk("idle_outs", {ps2clk_oe, ps2data_oe, tx_done, tx_err}, 0);
      if (tx_done) begin n_done++; last_pulse_cyc = cyc; end
      if (tx_err)  begin n_err++;  last_pulse_cyc = cyc; end
      if (tx_busy && !busy_prev) busy_rise_cyc = cyc;
      busy_prev  = tx_busy;
      pulse_prev = (tx_done | tx_err) & !rst;
      acc_prev   = tx_valid & tx_ready & !rst;
   end

   task automatic send(input logic [7:0] d);
      int w;
      w = 0;
      @(posedge clk); #1;
      while (!tx_ready && w < 5000) begin @(posedge clk); #1; w++; end
      if (!tx_ready) fail("ready_wait");
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_pulse(input int base, input int bound);
      int w;
      w = 0;
      while (n_done + n_err <= base && w < bound) begin
         @(negedge clk); #1; w++;
      end
      if (n_done + n_err <= base) fail("pulse_wait");
      repeat (2) @(negedge clk);
      #1;
   endtask

   // Keyboard: waits for request-to-send, clocks np pulses, samples bits
   // on rising clock, optionally ACKs, glitches or resets the host.
   task automatic dev_xfer(input int h, input int np, input bit ack,
                           input bit glitch, input int rst_at,
                           output logic [9:0] bits);
      int w;
      bits = '0;
      w = 0;
      while (!(ps2clk_in === 1'b1 && ps2data_in === 1'b0) && w < 2000) begin
         @(negedge clk); w++;
      end
      if (w >= 2000) begin
         fail("rts_wait");
         return;
      end
      repeat ($urandom_range(5, 40)) @(negedge clk);
      for (int k = 1; k <= np; k++) begin
         dev_clk_low = 1'b1;
         last_fall_cyc = cyc;
         if (k == rst_at) begin
            repeat (8) @(negedge clk);
            #2 rst = 1'b1;
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            return;
         end
         repeat (h) @(negedge clk);
         dev_clk_low = 1'b0;
         if (k <= 10) bits[k-1] = ps2data_in;
         if (k == 11) dev_data_low = 1'b0;
         for (int j = 0; j < h; j++) begin
            if (glitch && k <= 9 && j == h / 2)     dev_clk_low = 1'b1;
            if (glitch && k <= 9 && j == h / 2 + 2) dev_clk_low = 1'b0;
            if (ack && k == 10 && j == h / 2)       dev_data_low = 1'b1;
            @(negedge clk);
         end
      end
   endtask

   function automatic logic [9:0] exp_frame(input logic [7:0] d);
      logic par;
      par = ($countones(d) % 2 == 0);
      return {1'b1, par, d};
   endfunction

   initial begin
      logic [9:0] bits;
      logic [7:0] x;
      int b0, e0, d, rel, h, w;
      bit g;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_oes", {ps2clk_oe, ps2data_oe}, 0);
      chk("rst_code", tx_err_code, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (5) @(negedge clk);

      // 0xED with ACK.
      b0 = n_done; e0 = n_err;
      send(CMD_SET_LEDS);
      dev_xfer(12, 11, 1, 0, 0, bits);
      wait_pulse(b0 + e0, 4 * BITC);
      chk("ed_frame", bits, 10'h3ED);
      chk("ed_done", n_done - b0, 1);
      chk("ed_err", n_err - e0, 0);
      chk("ed_lines", {ps2clk_oe, ps2data_oe}, 0);

      // 0xFF with NACK.
      m_exp = ERR_NACK;
      b0 = n_done; e0 = n_err;
      send(CMD_RESET);
      dev_xfer(12, 11, 0, 0, 0, bits);
      wait_pulse(b0 + e0, 4 * BITC);
      chk("ff_frame", bits, 10'h3FF);
      chk("nack_err", n_err - e0, 1);
      chk("nack_done", n_done - b0, 0);
      chk("nack_code", tx_err_code, 2'b10);
      chk("nack_ready", tx_ready, 1);

      // No device: first-edge timeout.
      m_exp = ERR_TIMEOUT;
      b0 = n_done; e0 = n_err;
      send(8'h00);
      w = 0;
      while (ps2clk_oe !== 1'b1 && w < 100) begin @(negedge clk); #1; w++; end
      while (ps2clk_oe !== 1'b0 && w < 200) begin @(negedge clk); #1; w++; end
      if (w >= 200) fail("release_wait");
      rel = cyc;
      wait_pulse(b0 + e0, 2 * FEC);
      chk("first_tmo_cycles", last_pulse_cyc - rel, FEC + 1);
      chk("first_tmo_code", tx_err_code, 2'b01);
      chk("first_tmo_lines", {ps2clk_oe, ps2data_oe}, 0);

      // Device stops after 5 clocks.
      b0 = n_done; e0 = n_err;
      x = 8'($urandom);
      send(x);
      dev_xfer(12, 5, 0, 0, 0, bits);
      wait_pulse(b0 + e0, 4 * BITC);
      d = last_pulse_cyc - last_fall_cyc;
      chk("bit_tmo_window", (d >= BITC && d <= BITC + 12), 1);
      chk("bit_tmo_code", tx_err_code, 2'b01);
      chk("bit_tmo_err", n_err - e0, 1);
      chk("partial_bits", bits[4:0], x[4:0]);

      // Reset in the middle of a transfer.
      b0 = n_done; e0 = n_err;
      send(CMD_ENABLE);
      dev_xfer(12, 11, 1, 0, 3, bits);
      #1;
      chk("midrst_oes", {ps2clk_oe, ps2data_oe}, 0);
      chk("midrst_ready", tx_ready, 1);
      chk("midrst_busy", tx_busy, 0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      repeat (200) @(negedge clk);
      #1;
      chk("midrst_pulses", (n_done - b0) + (n_err - e0), 0);
      chk("midrst_code", tx_err_code, 0);

      // tx_valid held through a transfer.
      b0 = n_done; e0 = n_err;
      @(posedge clk); #1;
      tx_data  = 8'hA3;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_data = 8'h55;
      dev_xfer(12, 11, 1, 0, 0, bits);
      chk("hold_first", bits, 10'h3A3);
      wait_pulse(b0 + e0, 4 * BITC);
      repeat (3) @(negedge clk);
      #1;
      chk("hold_reaccept", busy_rise_cyc - last_pulse_cyc, 2);
      tx_valid = 1'b0;
      dev_xfer(12, 11, 1, 0, 0, bits);
      chk("hold_second", bits, 10'h355);
      repeat (100) @(negedge clk);
      #1;
      chk("hold_done_cnt", n_done - b0, 2);
      chk("hold_idle", tx_busy, 0);

`ifdef PS2_TX_GLITCH_FILTER_EN
      // Short clock glitches while sending.
      b0 = n_done; e0 = n_err;
      send(CMD_SET_LEDS);
      dev_xfer(12, 11, 1, 1, 0, bits);
      wait_pulse(b0 + e0, 4 * BITC);
      chk("glitch_frame", bits, 10'h3ED);
      chk("glitch_done", n_done - b0, 1);
`endif

      // Randomized ACKed transfers.
      for (int i = 0; i < 12; i++) begin
         x = 8'($urandom);
         h = $urandom_range(10, 16);
`ifdef PS2_TX_GLITCH_FILTER_EN
         g = ($urandom_range(0, 1) == 1);
`else
         g = 1'b0;
`endif
         b0 = n_done; e0 = n_err;
         send(x);
         dev_xfer(h, 11, 1, g, 0, bits);
         wait_pulse(b0 + e0, 4 * BITC);
         chk("rand_frame", bits, exp_frame(x));
         chk("rand_done", n_done - b0, 1);
         chk("rand_err", n_err - e0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
